rotary_input_ctrl: RTL and testbench

Front-panel input conditioning stage feeding the VGA pattern generator. Synchronises the rotary encoder (A/B quadrature, push), BTN0–2 and the scale-direction switch. Produces the registered control state the pattern generator consumes: `pattn`, `rot_indx`, `pattn_scal`, plus one-cycle event strobes. All debouncing, edge detection and saturation live here, so the pattern generator is purely combinational in its inputs.

---
 rtl/rotary_ctrl_pkg.sv | 18 +
 rtl/sync2.sv | 31 +++
 rtl/rotary_input_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_rotary_input_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_ctrl_pkg.sv
// Shared codes and types for the front-panel input conditioning stage.
package rotary_ctrl_pkg;

    localparam int DEB_CYCLES_DEF = 1048574;
    localparam int CNT_W          = 20;

    localparam logic [2:0] PATTN_NONE = 3'b000;
    localparam logic [2:0] PATTN_BARS = 3'b001;
    localparam logic [2:0] PATTN_TRI  = 3'b010;
    localparam logic [2:0] PATTN_CIRC = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } press_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous input, with a selectable reset level.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rotary_input_ctrl.sv
// Front-panel conditioning: synchronises encoder, push and buttons and produces
// the registered pattern/rotation/scale state plus one-cycle event strobes.
module rotary_input_ctrl
    import rotary_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int IDX_MAX    = 7,
    parameter int SCAL_MIN   = 1,
    parameter int SCAL_MAX   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rot_A,
    input  logic       rot_B,
    input  logic       rot_dwn,
    input  logic       BTN0,
    input  logic       BTN1,
    input  logic       BTN2,
    input  logic       scal_up,
    output logic [2:0] pattn,
    output logic [3:0] rot_indx,
    output logic [2:0] pattn_scal,
    output logic       step_pulse,
    output logic       step_dir,
    output logic       press_pulse
);

    localparam int             N_IN     = 7;
    // Encoder lines idle high so a reset at a detent does not look like motion.
    localparam logic [N_IN-1:0] IN_RST  = 7'b000_0011;
    localparam logic [3:0]     IDX_TOP  = 4'(IDX_MAX);
    localparam logic [2:0]     SCAL_LO  = 3'(SCAL_MIN);
    localparam logic [2:0]     SCAL_HI  = 3'(SCAL_MAX);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] sync_out;
    logic [N_IN-1:0] in_d, in_q;

    assign raw_in = {scal_up, BTN2, BTN1, BTN0, rot_dwn, rot_B, rot_A};

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_sync
            sync2 #(.RESET_VAL(IN_RST[gi])) u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (raw_in[gi]),
                .q     (sync_out[gi])
            );
        end
    endgenerate

    logic       a_s, b_s, dwn_s, scal_up_s;
    logic [2:0] btn_s;

    assign a_s       = in_q[0];
    assign b_s       = in_q[1];
    assign dwn_s     = in_q[2];
    assign btn_s     = in_q[5:3];
    assign scal_up_s = in_q[6];

    logic         deb_a_d, deb_a_q;
    logic         deb_b_d, deb_b_q;
    logic         deb_a_prev_d, deb_a_prev_q;
    logic         step;
    logic [3:0]   rot_indx_d, rot_indx_q;
    logic         step_pulse_d, step_pulse_q;
    logic         step_dir_d, step_dir_q;
    press_state_e state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic         press_pulse_d, press_pulse_q;
    logic [2:0]   pattn_scal_d, pattn_scal_q;
    logic [2:0]   pattn_d, pattn_q;

    assign in_d = sync_out;

    // Quadrature filter: deb_A only moves when both lines agree, deb_B only when they differ.
    always_comb begin
        deb_a_d = deb_a_q;
        deb_b_d = deb_b_q;
        if (a_s && b_s) begin
            deb_a_d = 1'b1;
        end else if (!a_s && !b_s) begin
            deb_a_d = 1'b0;
        end else begin
            deb_b_d = b_s;
        end
        deb_a_prev_d = deb_a_q;
    end

    assign step = deb_a_q & ~deb_a_prev_q;

    always_comb begin
        rot_indx_d   = rot_indx_q;
        step_dir_d   = step_dir_q;
        step_pulse_d = step;
        if (step) begin
            step_dir_d = deb_b_q;
            if (deb_b_q) begin
                rot_indx_d = (rot_indx_q == 4'd0) ? IDX_TOP : rot_indx_q - 4'd1;
            end else begin
                rot_indx_d = (rot_indx_q == IDX_TOP) ? 4'd0 : rot_indx_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dwn_s) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            COUNT: begin
                if (!dwn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d       = HELD;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!dwn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Scale saturates at both ends; direction is whatever the switch reads in the pulse cycle.
    always_comb begin
        pattn_scal_d = pattn_scal_q;
        if (press_pulse_q) begin
            if (scal_up_s && (pattn_scal_q < SCAL_HI)) begin
                pattn_scal_d = pattn_scal_q + 3'd1;
            end else if (!scal_up_s && (pattn_scal_q > SCAL_LO)) begin
                pattn_scal_d = pattn_scal_q - 3'd1;
            end
        end
    end

    always_comb begin
        pattn_d = pattn_q;
        if (btn_s[0]) begin
            pattn_d = PATTN_BARS;
        end else if (btn_s[1]) begin
            pattn_d = PATTN_TRI;
        end else if (btn_s[2]) begin
            pattn_d = PATTN_CIRC;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_q          <= IN_RST;
            deb_a_q       <= 1'b1;
            deb_b_q       <= 1'b1;
            deb_a_prev_q  <= 1'b1;
            rot_indx_q    <= 4'd0;
            step_pulse_q  <= 1'b0;
            step_dir_q    <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            press_pulse_q <= 1'b0;
            pattn_scal_q  <= SCAL_LO;
            pattn_q       <= PATTN_NONE;
        end else begin
            in_q          <= in_d;
            deb_a_q       <= deb_a_d;
            deb_b_q       <= deb_b_d;
            deb_a_prev_q  <= deb_a_prev_d;
            rot_indx_q    <= rot_indx_d;
            step_pulse_q  <= step_pulse_d;
            step_dir_q    <= step_dir_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse_q <= press_pulse_d;
            pattn_scal_q  <= pattn_scal_d;
            pattn_q       <= pattn_d;
        end
    end

    assign pattn       = pattn_q;
    assign rot_indx    = rot_indx_q;
    assign pattn_scal  = pattn_scal_q;
    assign step_pulse  = step_pulse_q;
    assign step_dir    = step_dir_q;
    assign press_pulse = press_pulse_q;

endmodule

// File: tb/tb_rotary_input_ctrl.sv
// Bench for rotary_input_ctrl: sample-stream reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rotary_input_ctrl;

    localparam int DEB   = 16;
    localparam int IMAX  = 7;
    localparam int SMIN  = 1;
    localparam int SMAX  = 5;
    localparam int MAXE  = 8192;

    logic       clk = 1'b0;
    logic       reset, rot_A, rot_B, rot_dwn, BTN0, BTN1, BTN2, scal_up;
    logic [2:0] pattn, pattn_scal;
    logic [3:0] rot_indx;
    logic       step_pulse, step_dir, press_pulse;

    rotary_input_ctrl #(
        .DEB_CYCLES (DEB),
        .IDX_MAX    (IMAX),
        .SCAL_MIN   (SMIN),
        .SCAL_MAX   (SMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rot_A       (rot_A),
        .rot_B       (rot_B),
        .rot_dwn     (rot_dwn),
        .BTN0        (BTN0),
        .BTN1        (BTN1),
        .BTN2        (BTN2),
        .scal_up     (scal_up),
        .pattn       (pattn),
        .rot_indx    (rot_indx),
        .pattn_scal  (pattn_scal),
        .step_pulse  (step_pulse),
        .step_dir    (step_dir),
        .press_pulse (press_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int press_seen = 0;
    int step_seen  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model over the stream of input samples taken at each rising edge.
    bit  s_a[MAXE], s_b[MAXE], s_dwn[MAXE], s_su[MAXE];
    bit  [2:0] s_btn[MAXE];
    int  run_len[MAXE];
    bit  d_a[MAXE], d_b[MAXE];
    int  cyc = 0;
    int  last_rst = -1000;
    int  m_pattn = 0, m_rot = 0, m_scal = SMIN, m_dir = 0, m_step = 0, m_press = 0;

    always @(posedge clk) begin
        int  e, m;
        bit  vld, pa, pb, p_prev, s;
        e = cyc;
        cyc++;
        if (e >= MAXE) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", e, MAXE);
            $fatal(1, "cycle budget exhausted");
        end
        s_a[e] = rot_A;  s_b[e] = rot_B;  s_dwn[e] = rot_dwn;
        s_su[e] = scal_up;  s_btn[e] = {BTN2, BTN1, BTN0};
        if (!reset) last_rst = e;

        m   = e - 3;
        vld = (m >= 0) && (m > last_rst);
        if (m >= 0) begin
            if (vld) begin
                run_len[m] = s_dwn[m] ? ((m > 0 ? run_len[m-1] : 0) + 1) : 0;
                pa = (m > 0) ? d_a[m-1] : 1'b1;
                pb = (m > 0) ? d_b[m-1] : 1'b1;
                if (s_a[m] && s_b[m])        begin d_a[m] = 1'b1; d_b[m] = pb; end
                else if (!s_a[m] && !s_b[m]) begin d_a[m] = 1'b0; d_b[m] = pb; end
                else                          begin d_a[m] = pa;   d_b[m] = s_b[m]; end
            end else begin
                run_len[m] = 0;
                d_a[m] = 1'b1;
                d_b[m] = 1'b1;
            end
        end

        if (!reset) begin
            m_pattn = 0; m_rot = 0; m_scal = SMIN; m_dir = 0; m_step = 0; m_press = 0;
        end else begin
            p_prev  = m_press[0];
            m_press = (vld && run_len[m] == DEB) ? 1 : 0;
            if (p_prev) begin
                if (s_su[m] && m_scal < SMAX)       m_scal++;
                else if (!s_su[m] && m_scal > SMIN) m_scal--;
            end
            if (vld) begin
                if (s_btn[m][0])      m_pattn = 1;
                else if (s_btn[m][1]) m_pattn = 2;
                else if (s_btn[m][2]) m_pattn = 4;
            end
            s = (e - 5 > last_rst) && (e - 5 >= 0) && d_a[e-4] && !d_a[e-5];
            m_step = s ? 1 : 0;
            if (s) begin
                m_dir = d_b[e-4] ? 1 : 0;
                if (d_b[e-4]) m_rot = (m_rot == 0) ? IMAX : m_rot - 1;
                else          m_rot = (m_rot == IMAX) ? 0 : m_rot + 1;
            end
        end

        #1;
        chk("pattn",       pattn,       m_pattn);
        chk("rot_indx",    rot_indx,    m_rot);
        chk("pattn_scal",  pattn_scal,  m_scal);
        chk("step_pulse",  step_pulse,  m_step);
        chk("step_dir",    step_dir,    m_dir);
        chk("press_pulse", press_pulse, m_press);
        if (press_pulse === 1'b1) press_seen++;
        if (step_pulse === 1'b1)  step_seen++;
    end

    task automatic press(input int hold);
        rot_dwn = 1'b1;
        repeat (hold) @(negedge clk);
        rot_dwn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // One detent through the full quadrature cycle, checking the exact step latency.
    task automatic enc_step(input bit ccw, input int exp_rot);
        bit [1:0] seq [3];
        if (ccw) begin seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b01; end
        else     begin seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b10; end
        for (int i = 0; i < 3; i++) begin
            {rot_A, rot_B} = seq[i];
            repeat (5) @(negedge clk);
        end
        rot_A = 1'b1; rot_B = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("step_early", step_pulse, 0);
        @(posedge clk);
        #2;
        chk("step_at_k4", step_pulse, 1);
        chk("step_rot",   rot_indx,   exp_rot);
        chk("step_dir",   step_dir,   ccw);
        @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    int cw_exp [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        reset = 1'b0; rot_A = 1'b0; rot_B = 1'b0; rot_dwn = 1'b0;
        BTN0 = 1'b0; BTN1 = 1'b0; BTN2 = 1'b0; scal_up = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        press_seen = 0; step_seen = 0;
        repeat (100) @(negedge clk);
        chk("idle_pattn", pattn, 0);
        chk("idle_rot",   rot_indx, 0);
        chk("idle_scal",  pattn_scal, 1);
        chk("idle_press_count", press_seen, 0);
        chk("idle_step_count",  step_seen, 0);

        // park the encoder at its detent and reset there
        rot_A = 1'b1; rot_B = 1'b1; reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; scal_up = 1'b1;
        repeat (10) @(negedge clk);

        // first press: pulse exactly after edge 18
        press_seen = 0;
        rot_dwn = 1'b1;
        repeat (18) @(posedge clk);
        #2;
        chk("press_edge17", press_pulse, 0);
        @(posedge clk);
        #2;
        chk("press_edge18", press_pulse, 1);
        @(posedge clk);
        #2;
        chk("press_edge19", press_pulse, 0);
        chk("scal_after_1", pattn_scal, 2);
        @(negedge clk);
        repeat (20) @(negedge clk);
        rot_dwn = 1'b0;
        repeat (8) @(negedge clk);
        chk("one_pulse_per_hold", press_seen, 1);

        for (int i = 0; i < 4; i++) press(25);
        chk("scal_sat_hi", pattn_scal, 5);
        scal_up = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 6; i++) press(20);
        chk("scal_sat_lo", pattn_scal, 1);

        // bounce: 10 high, 2 low, 20 high
        scal_up = 1'b1;
        repeat (5) @(negedge clk);
        press_seen = 0;
        rot_dwn = 1'b1;
        repeat (10) @(negedge clk);
        rot_dwn = 1'b0;
        repeat (2) @(negedge clk);
        rot_dwn = 1'b1;
        repeat (20) @(negedge clk);
        rot_dwn = 1'b0;
        repeat (8) @(negedge clk);
        chk("bounce_pulses", press_seen, 1);
        chk("bounce_scal",   pattn_scal, 2);

        // reset in the middle of a long hold: re-qualifies once afterwards
        press_seen = 0;
        rot_dwn = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        rot_dwn = 1'b0;
        repeat (8) @(negedge clk);
        chk("reset_press_pulses", press_seen, 1);
        chk("reset_press_scal",   pattn_scal, 2);

        for (int i = 0; i < 9; i++) enc_step(1'b0, cw_exp[i]);
        enc_step(1'b1, 0);
        enc_step(1'b1, 7);

        // A chatters while B stays high: never both low, so no detent
        step_seen = 0;
        for (int i = 0; i < 5; i++) begin
            rot_A = 1'b0;
            repeat (2) @(negedge clk);
            rot_A = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("chatter_steps", step_seen, 0);
        chk("chatter_rot",   rot_indx, 7);

        BTN1 = 1'b1; BTN2 = 1'b1;
        repeat (6) @(negedge clk);
        chk("btn12_pattn", pattn, 2);
        BTN1 = 1'b0; BTN2 = 1'b0;
        repeat (6) @(negedge clk);
        chk("btn_hold_pattn", pattn, 2);
        BTN2 = 1'b1;
        repeat (6) @(negedge clk);
        chk("btn2_pattn", pattn, 4);
        BTN2 = 1'b0;
        BTN0 = 1'b1;
        repeat (6) @(negedge clk);
        chk("btn0_pattn", pattn, 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pattn", pattn, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("btn_post_rst_e2", pattn, 0);
        @(posedge clk);
        #2;
        chk("btn_post_rst_e3", pattn, 1);
        @(negedge clk);
        BTN0 = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
